// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter and access sequencer for the shared data memory
//   (asynchronous read, level-sensitive write enable). Port 0 is the CPU
//   load/store stage, port 1 the debug/loader port. Requests are
//   serialised round-robin, the memory lines are driven from registered
//   copies of the winning request, read data is captured after WAIT_CYC
//   cycles and a single-cycle ack is returned to the owner.
//
//   Sequence per access: IDLE (arbitrate) -> BUSY (WAIT_CYC cycles)
//   -> RESP (ack) -> IDLE. The write enable is high only in the first
//   BUSY cycle, so the memory always sees a clean one-cycle pulse.
//
// Parameters
//   DATA_W     data and address width
//   WAIT_CYC   cycles the address is held before read data is captured (1..15)
//   MEM_DEPTH  number of memory entries, used by the optional range check
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req0/we0/addr0/wdata0         port 0 request, held until ack0
//   ack0, rdata0                  port 0 completion pulse and read data
//   req1/we1/addr1/wdata1         port 1 request, held until ack1
//   ack1, rdata1                  port 1 completion pulse and read data
//   gntId, busy                   current owner, access in progress
//   memReadAddr, memWriteAddr     memory addresses (passed unmodified)
//   memDataIn, memEnableWrite     memory write data and write enable
//   memDataOut                    memory read data
//   err0, err1                    only with DMEM_ARB_RANGE_CHK_EN defined:
//                                 out-of-range flag, pulsed with the ack
//
// Build option
//   DMEM_ARB_RANGE_CHK_EN  when defined, an address >= MEM_DEPTH is
//   flagged on err0/err1, its write is suppressed and its rdata reads 0.

module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int WAIT_CYC  = 1,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              gntId,
  output logic              busy,
  output logic [DATA_W-1:0] memReadAddr,
  output logic [DATA_W-1:0] memWriteAddr,
  output logic [DATA_W-1:0] memDataIn,
  output logic              memEnableWrite,
  input  logic [DATA_W-1:0] memDataOut
`ifdef DMEM_ARB_RANGE_CHK_EN
  ,
  output logic              err0,
  output logic              err1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              gnt_id_q, gnt_id_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
`ifdef DMEM_ARB_RANGE_CHK_EN
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
`endif

  // Winner selection: a lone requester wins outright; on a tie the port
  // that was not granted last time wins.
  logic              pick;
  logic              sel_we;
  logic              sel_err;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] cap_data;

  always_comb begin
    pick      = (req0 && req1) ? ~last_gnt_q : req1;
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
    sel_err   = RANGE_CHK && (sel_addr >= DATA_W'(MEM_DEPTH));
    // A flagged access returns zero instead of whatever the memory aliases to.
    cap_data  = err_q ? '0 : memDataOut;
  end

  // Next-state and next-output logic. Pulse outputs (write enable, acks,
  // errors) default low so each is high for exactly one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_we_d   = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
`ifdef DMEM_ARB_RANGE_CHK_EN
    err0_d     = 1'b0;
    err1_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d    = BUSY;
          cnt_d      = 4'(WAIT_CYC - 1);
          gnt_id_d   = pick;
          last_gnt_d = pick;
          we_d       = sel_we;
          err_d      = sel_err;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          busy_d     = 1'b1;
          // Raising the enable on the grant edge confines it to the
          // first BUSY cycle.
          mem_we_d   = sel_we && !sel_err;
        end
      end

      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          ack0_d  = ~gnt_id_q;
          ack1_d  = gnt_id_q;
`ifdef DMEM_ARB_RANGE_CHK_EN
          err0_d  = err_q && !gnt_id_q;
          err1_d  = err_q && gnt_id_q;
`endif
          // Reads capture memory data; a flagged access of either kind
          // loads zero so the requester never sees stale data.
          if (!we_q || err_q) begin
            if (gnt_id_q) rdata1_d = cap_data;
            else          rdata0_d = cap_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        // Dead cycle: the requester drops req while its ack is visible.
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register. Reset aborts any access on the same edge, which also
  // drops the write enable and suppresses any pending ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      gnt_id_q   <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef DMEM_ARB_RANGE_CHK_EN
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
`ifdef DMEM_ARB_RANGE_CHK_EN
      err0_q     <= err0_d;
      err1_q     <= err1_d;
`endif
    end
  end

  // The latched request feeds the memory directly, so the address and
  // write data hold their last values outside BUSY.
  assign memReadAddr    = addr_q;
  assign memWriteAddr   = addr_q;
  assign memDataIn      = wdata_q;
  assign memEnableWrite = mem_we_q;
  assign gntId          = gnt_id_q;
  assign busy           = busy_q;
  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
`ifdef DMEM_ARB_RANGE_CHK_EN
  assign err0           = err0_q;
  assign err1           = err1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Instance "dut" runs with WAIT_CYC = 1
//   and owns a 256-entry memory model; instance "dut3" runs with
//   WAIT_CYC = 3 and only reads the same memory. Inputs change 1 ns after
//   a rising edge and outputs are checked at that same point.

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, gntId, busy, memEnableWrite;
  logic [31:0] rdata0, rdata1, memReadAddr, memWriteAddr, memDataIn, memDataOut;
`ifdef DMEM_ARB_RANGE_CHK_EN
  logic        err0, err1;
`endif

  logic        req0_3;
  logic [31:0] addr0_3;
  logic        ack0_3, ack1_3, gntId_3, busy_3, memEnableWrite_3;
  logic [31:0] rdata0_3, rdata1_3, memReadAddr_3, memWriteAddr_3, memDataIn_3, memDataOut_3;
`ifdef DMEM_ARB_RANGE_CHK_EN
  logic        err0_3, err1_3;
`endif

  logic [31:0] mem [256];
  logic        preloaded = 1'b0;

  int compCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .WAIT_CYC(1), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .gntId(gntId), .busy(busy),
    .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr),
    .memDataIn(memDataIn), .memEnableWrite(memEnableWrite),
    .memDataOut(memDataOut)
`ifdef DMEM_ARB_RANGE_CHK_EN
    , .err0(err0), .err1(err1)
`endif
  );

  dmem_arbiter #(.DATA_W(32), .WAIT_CYC(3), .MEM_DEPTH(256)) dut3 (
    .clk(clk), .rst(rst),
    .req0(req0_3), .we0(1'b0), .addr0(addr0_3), .wdata0(32'h0),
    .ack0(ack0_3), .rdata0(rdata0_3),
    .req1(1'b0), .we1(1'b0), .addr1(32'h0), .wdata1(32'h0),
    .ack1(ack1_3), .rdata1(rdata1_3),
    .gntId(gntId_3), .busy(busy_3),
    .memReadAddr(memReadAddr_3), .memWriteAddr(memWriteAddr_3),
    .memDataIn(memDataIn_3), .memEnableWrite(memEnableWrite_3),
    .memDataOut(memDataOut_3)
`ifdef DMEM_ARB_RANGE_CHK_EN
    , .err0(err0_3), .err1(err1_3)
`endif
  );

  // Memory model: asynchronous read, write committed at the rising edge
  // that ends a write-enable cycle. The memory sits in the same reset
  // domain, so a reset on that edge cancels the write.
  assign memDataOut   = mem[memReadAddr[7:0]];
  assign memDataOut_3 = mem[memReadAddr_3[7:0]];

  always @(posedge clk) begin
    if (rst && !preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]    <= 32'h10000011;
      mem[8]    <= 32'h20000022;
      mem[12]   <= 32'h30000033;
      preloaded <= 1'b1;
    end else if (memEnableWrite && !rst) begin
      mem[memWriteAddr[7:0]] <= memDataIn;
    end
  end

  // Advance one clock and settle 1 ns past the edge.
  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every output of the main instance at its reset value.
  task automatic checkResetState(input string tag);
    checkOutput({tag, " ack0"}, {31'b0, ack0}, 32'h0);
    checkOutput({tag, " ack1"}, {31'b0, ack1}, 32'h0);
    checkOutput({tag, " busy"}, {31'b0, busy}, 32'h0);
    checkOutput({tag, " gntId"}, {31'b0, gntId}, 32'h0);
    checkOutput({tag, " memEnableWrite"}, {31'b0, memEnableWrite}, 32'h0);
    checkOutput({tag, " memReadAddr"}, memReadAddr, 32'h0);
    checkOutput({tag, " memWriteAddr"}, memWriteAddr, 32'h0);
    checkOutput({tag, " memDataIn"}, memDataIn, 32'h0);
    checkOutput({tag, " rdata0"}, rdata0, 32'h0);
    checkOutput({tag, " rdata1"}, rdata1, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    req0_3 = 1'b0; addr0_3 = '0;

    // Reset values
    applyStimulus;
    applyStimulus;
    checkResetState("reset");
    checkOutput("reset busy_3", {31'b0, busy_3}, 32'h0);
    rst = 1'b0;
    applyStimulus;

    // Tie right after reset, both requests held: 0,1,0,1 with one-cycle acks
    $display("[TB] round-robin tie");
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus;
      checkOutput($sformatf("rr ack0 c%0d", k), {31'b0, ack0}, {31'b0, (k == 2 || k == 8)});
      checkOutput($sformatf("rr ack1 c%0d", k), {31'b0, ack1}, {31'b0, (k == 5 || k == 11)});
      if (k == 1) checkOutput("rr first gntId", {31'b0, gntId}, 32'h0);
      if (k == 4) checkOutput("rr second gntId", {31'b0, gntId}, 32'h1);
      if (k == 2) checkOutput("rr rdata0", rdata0, 32'h20000022);
      if (k == 5) checkOutput("rr rdata1", rdata1, 32'h10000011);
    end
    req0 = 1'b0; req1 = 1'b0;
    applyStimulus;

    // Port 0 write, WAIT_CYC = 1
    $display("[TB] port 0 write");
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd40; wdata0 = 32'h12345678;
    applyStimulus;
    checkOutput("wr memEnableWrite first BUSY", {31'b0, memEnableWrite}, 32'h1);
    checkOutput("wr memWriteAddr", memWriteAddr, 32'd40);
    checkOutput("wr memDataIn", memDataIn, 32'h12345678);
    checkOutput("wr busy", {31'b0, busy}, 32'h1);
    checkOutput("wr gntId", {31'b0, gntId}, 32'h0);
    checkOutput("wr ack0 early", {31'b0, ack0}, 32'h0);
    applyStimulus;
    checkOutput("wr ack0", {31'b0, ack0}, 32'h1);
    checkOutput("wr ack1 idle", {31'b0, ack1}, 32'h0);
    checkOutput("wr memEnableWrite dropped", {31'b0, memEnableWrite}, 32'h0);
    req0 = 1'b0; we0 = 1'b0;
    applyStimulus;
    checkOutput("wr ack0 one cycle", {31'b0, ack0}, 32'h0);
    checkOutput("wr busy done", {31'b0, busy}, 32'h0);
    checkOutput("wr memory word", mem[40], 32'h12345678);
    checkOutput("wr memWriteAddr held", memWriteAddr, 32'd40);

    // Port 1 read of preloaded address 4
    $display("[TB] port 1 read");
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
    applyStimulus;
    checkOutput("rd gntId", {31'b0, gntId}, 32'h1);
    checkOutput("rd memReadAddr", memReadAddr, 32'd4);
    checkOutput("rd memEnableWrite", {31'b0, memEnableWrite}, 32'h0);
    applyStimulus;
    checkOutput("rd ack1", {31'b0, ack1}, 32'h1);
    checkOutput("rd ack0 idle", {31'b0, ack0}, 32'h0);
    checkOutput("rd rdata1", rdata1, 32'h10000011);
    req1 = 1'b0;
    applyStimulus;
    checkOutput("rd ack1 one cycle", {31'b0, ack1}, 32'h0);
    applyStimulus;
    checkOutput("rd rdata1 held", rdata1, 32'h10000011);

    // WAIT_CYC = 3 instance: port 0 read of address 8
    $display("[TB] WAIT_CYC=3 read");
    req0_3 = 1'b1; addr0_3 = 32'd8;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus;
      checkOutput($sformatf("w3 busy c%0d", k), {31'b0, busy_3}, {31'b0, (k <= 4)});
      checkOutput($sformatf("w3 ack0 c%0d", k), {31'b0, ack0_3}, {31'b0, (k == 4)});
      if (k == 4) begin
        checkOutput("w3 rdata0", rdata0_3, 32'h20000022);
        req0_3 = 1'b0;
      end
    end

    // Reset during the first BUSY cycle of a write to address 12
    $display("[TB] reset abort");
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd12; wdata0 = 32'hBADBAD00;
    applyStimulus;
    checkOutput("abort memEnableWrite before reset", {31'b0, memEnableWrite}, 32'h1);
    rst = 1'b1;
    applyStimulus;
    checkResetState("abort");
    rst = 1'b0; req0 = 1'b0; we0 = 1'b0;
    applyStimulus;
    checkOutput("abort no late ack0", {31'b0, ack0}, 32'h0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd12;
    applyStimulus;
    applyStimulus;
    checkOutput("abort readback ack0", {31'b0, ack0}, 32'h1);
    checkOutput("abort readback rdata0", rdata0, 32'h30000033);
    req0 = 1'b0;
    applyStimulus;

`ifdef DMEM_ARB_RANGE_CHK_EN
    // Out-of-range write on port 1, preceded by a read so rdata1 is nonzero
    $display("[TB] range check");
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
    applyStimulus;
    applyStimulus;
    checkOutput("rc pre-read rdata1", rdata1, 32'h10000011);
    checkOutput("rc pre-read err1", {31'b0, err1}, 32'h0);
    req1 = 1'b0;
    applyStimulus;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd300; wdata1 = 32'hDEADBEEF;
    applyStimulus;
    checkOutput("rc memEnableWrite suppressed", {31'b0, memEnableWrite}, 32'h0);
    checkOutput("rc busy", {31'b0, busy}, 32'h1);
    applyStimulus;
    checkOutput("rc ack1", {31'b0, ack1}, 32'h1);
    checkOutput("rc err1", {31'b0, err1}, 32'h1);
    checkOutput("rc err0", {31'b0, err0}, 32'h0);
    checkOutput("rc rdata1 zero", rdata1, 32'h0);
    checkOutput("rc memEnableWrite still low", {31'b0, memEnableWrite}, 32'h0);
    req1 = 1'b0; we1 = 1'b0;
    applyStimulus;
    checkOutput("rc err1 one cycle", {31'b0, err1}, 32'h0);
    checkOutput("rc memory untouched", mem[44], 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer for the single shared data memory (32-bit words, 256 entries, asynchronous read, level-sensitive write enable).
- Port 0 is the CPU load/store stage; port 1 is the debug/loader port.
- Serialises requests, drives the memory address/data/write-enable lines, waits a fixed latency, and returns read data with a one-cycle ack.
- Guarantees the memory write enable is a clean single-cycle pulse.

Parameters:
- DATA_W, 32, data and address width.
- WAIT_CYC, 1, cycles the memory address is held before read data is captured (legal range 1..15).
- MEM_DEPTH, 256, number of memory entries; used only by the optional range check.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0: 1 = write, 0 = read; stable while req0 is high.
- addr0  in  DATA_W  port 0 address; stable while req0 is high.
- wdata0  in  DATA_W  port 0 write data; stable while req0 is high.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DATA_W  port 0 read data; valid with ack0 and held until the next read ack0.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- gntId  out  1  requester currently owning the memory; valid when busy = 1.
- busy  out  1  high in the BUSY and RESP states.
- memReadAddr  out  DATA_W  to the memory read address.
- memWriteAddr  out  DATA_W  to the memory write address.
- memDataIn  out  DATA_W  to the memory write data.
- memEnableWrite  out  1  to the memory write enable.
- memDataOut  in  DATA_W  from the memory read data.

Behaviour:
- Reset values:
  - state = IDLE; ack0 = ack1 = 0; busy = 0; gntId = 0; memEnableWrite = 0.
  - memReadAddr = memWriteAddr = memDataIn = 0; rdata0 = rdata1 = 0.
  - lastGnt = 1, so port 0 wins the first tie.
- Reset asserted in any state aborts the transfer in progress: no ack is issued and memEnableWrite drops in the same edge.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requesting: grant the port that is not lastGnt (round-robin).
  - On grant: register gntId and lastGnt, latch the winner's we/addr/wdata into internal registers, go to BUSY, load cnt = WAIT_CYC-1.
- BUSY:
  - memReadAddr and memWriteAddr are driven from the latched address.
  - memDataIn is driven from the latched wdata.
  - memEnableWrite = 1 only in the first BUSY cycle, and only for writes.
  - cnt decrements each cycle. When cnt = 0, go to RESP; for reads, capture memDataOut into rdata of the granted port on that edge.
- RESP:
  - ack of the granted port = 1 for exactly this cycle; the other ack stays 0.
  - Next state is always IDLE. This dead cycle lets the requester drop req; a req still high in IDLE is a new request.
- Latency: req sampled in IDLE at edge N; memEnableWrite/address driven at N+1; ack high in cycle N+1+WAIT_CYC. Throughput is one access per WAIT_CYC+2 cycles.
- A request arriving on the losing port while the other port is being served waits; it is granted in the next IDLE. No starvation: worst-case wait is one full access.
- Write-then-read of the same address by either port returns the written data; accesses are strictly serialised.
- The memory address is passed unmodified (the memory indexes entries directly by address).
- Write-path memory outputs hold their last values outside BUSY; memEnableWrite is 0 outside BUSY.

Optional Feature:
- Macro: DMEM_ARB_RANGE_CHK_EN.
- Defined:
  - Extra outputs err0 and err1 (1 bit each, reset 0), pulsed together with the matching ack.
  - err is set when the latched address ≥ MEM_DEPTH.
  - On an error: memEnableWrite is suppressed for the whole access, rdata is loaded with 0, and timing is unchanged.
- Not defined: err ports are absent and all addresses are passed through unchecked.

Test Plan:
- Reset, then port 0 writes 0x12345678 to addr 40 with WAIT_CYC = 1 -> memEnableWrite high exactly 1 cycle with memWriteAddr = 40; ack0 at the 2nd edge after req is sampled.
- Port 1 reads addr 4 (preloaded 0x10000011) -> ack1 pulse with rdata1 = 0x10000011; rdata1 holds that value after req1 drops.
- req0 and req1 asserted in the same cycle after reset, both held -> order is port 0, port 1, port 0, port 1; each ack lasts one cycle; never two acks at once.
- WAIT_CYC = 3, port 0 reads addr 8 -> ack0 exactly 4 cycles after the grant edge, rdata0 = 0x20000022; busy high for 4 cycles.
- rst asserted in the first BUSY cycle of a write to addr 12 -> no ack; all outputs at reset values on the next edge; a following read of addr 12 returns 0x30000033 when the write-enable pulse was cut by reset.
- With DMEM_ARB_RANGE_CHK_EN defined, port 1 writes 0xDEADBEEF to addr 300 -> err1 and ack1 pulse together, memEnableWrite stays 0, rdata1 = 0.
